mem_access_ctrl: RTL and testbench

//  Sequences the single-port 512-word RAM through the MAR for two requesters: instruction fetch (if_*) and load/store (ls_*).

---
 rtl/mem_access_ctrl_if.sv | 32 +++
 rtl/mem_access_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request, RAM-strobe and MAR signals between the control unit, mem_access_ctrl and the MAR/RAM pair.
// slave: the controller side; master: requesters plus MAR/RAM.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_ack;
  logic              ls_req;
  logic              ls_we;
  logic [DATA_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic [DATA_W-1:0] rdata;
  logic              mar_Rin;
  logic [DATA_W-1:0] mar_dIn;
  logic              ram_re;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
    output if_ack, ls_ack, rdata, mar_Rin, mar_dIn, ram_re, ram_we, ram_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
    input  if_ack, ls_ack, rdata, mar_Rin, mar_dIn, ram_re, ram_we, ram_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Fetch / load-store access sequencer for the MAR + single-port RAM; MEM_ARB_RR_EN selects round-robin
// arbitration (default: fixed priority, ls over if). States: IDLE | S_MAR load MAR | S_ACC strobe RAM | S_WAIT read latency | S_ACK ack pulse
module mem_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               clr,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, S_MAR, S_ACC, S_WAIT, S_ACK} state_t;

  // MAR only decodes the low ADDR_W bits, so higher address bits wrap silently
  localparam logic [DATA_W-1:0] ADDR_MASK = {{(DATA_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

  state_t            state;
  logic              gnt_ls;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        wait_cnt;
  logic              pick_ls;
  logic [DATA_W-1:0] pick_addr;

`ifdef MEM_ARB_RR_EN
  logic rr_ls_next;

  always_comb begin
    pick_ls = bus.ls_req;
    if (bus.ls_req && bus.if_req) pick_ls = rr_ls_next;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      rr_ls_next <= 1'b1;
    else if (state == IDLE && (bus.ls_req || bus.if_req))
      rr_ls_next <= !pick_ls;
  end
`else
  always_comb begin
    pick_ls = bus.ls_req;
  end
`endif

  assign pick_addr = pick_ls ? bus.ls_addr : bus.if_addr;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      gnt_ls        <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wait_cnt      <= '0;
      bus.if_ack    <= 1'b0;
      bus.ls_ack    <= 1'b0;
      bus.rdata     <= '0;
      bus.mar_Rin   <= 1'b0;
      bus.mar_dIn   <= '0;
      bus.ram_re    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.mar_Rin   <= 1'b0;
      bus.mar_dIn   <= '0;
      bus.ram_re    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.ls_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ls_req || bus.if_req) begin
            gnt_ls      <= pick_ls;
            addr_q      <= pick_addr;
            we_q        <= pick_ls && bus.ls_we;
            wdata_q     <= bus.ls_wdata;
            bus.mar_Rin <= 1'b1;
            bus.mar_dIn <= pick_addr & ADDR_MASK;
            bus.busy    <= 1'b1;
            state       <= S_MAR;
          end
        end
        S_MAR: begin
          if (we_q) begin
            bus.ram_we    <= 1'b1;
            bus.ram_wdata <= wdata_q;
          end else begin
            bus.ram_re <= 1'b1;
          end
          state <= S_ACC;
        end
        S_ACC: begin
          if (we_q) begin
            bus.ls_ack <= gnt_ls;
            bus.if_ack <= !gnt_ls;
            state      <= S_ACK;
          end else begin
            wait_cnt <= 3'(RD_LAT - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            bus.rdata  <= bus.ram_rdata;
            bus.ls_ack <= gnt_ls;
            bus.if_ack <= !gnt_ls;
            state      <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_ACK: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // addr_q keeps the full requested address; only its masked form reaches the MAR
  logic unused_ok;
  assign unused_ok = ^addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a cycle-offset transaction model checked every cycle, plus directed literal checks.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_W(32)) bus ();
  mem_access_ctrl_if #(.DATA_W(32)) bus3 ();

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) dut (.clk(clk), .clr(clr), .bus(bus));
  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) dut3 (.clk(clk), .clr(clr), .bus(bus3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [8:0] a);
    return (a == 9'h123) ? 32'hDEAD_BEEF : {16'hA5C3, 7'h0, a};
  endfunction

  // RAM + MAR emulation for the RD_LAT=1 instance
  logic [31:0] mem [512];
  bit          mem_wr [512];
  logic [8:0]  mar_q;

  always @(posedge clk) begin
    if (bus.mar_Rin) mar_q <= bus.mar_dIn[8:0];
    if (bus.ram_we) begin
      mem[mar_q]    <= bus.ram_wdata;
      mem_wr[mar_q] <= 1'b1;
    end
    bus.ram_rdata <= bus.ram_re ? (mem_wr[mar_q] ? mem[mar_q] : init_val(mar_q)) : 32'hBAD0_BAD0;
  end

  // RAM + MAR emulation for the RD_LAT=3 instance (read-only)
  logic [8:0]  mar3;
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    if (bus3.mar_Rin) mar3 <= bus3.mar_dIn[8:0];
    p1 <= bus3.ram_re ? ((mar3 == 9'h040) ? 32'hCAFE_F00D : init_val(mar3)) : 32'hBAD0_BAD0;
    p2 <= p1;
    bus3.ram_rdata <= p2;
  end

  // Transaction model: k is the cycle offset since the sampling edge (0 = idle)
  int          k = 0;
  logic        m_ls = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, exp_rdata = '0;
  logic [31:0] mmem [512];
  bit          mmem_wr [512];
`ifdef MEM_ARB_RR_EN
  logic        ptr_ls = 1'b1;
`endif

  function automatic int ack_off(input logic we);
    return we ? 3 : 4;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      k = 0;
      exp_rdata = '0;
`ifdef MEM_ARB_RR_EN
      ptr_ls = 1'b1;
`endif
    end else if (k == 0) begin
      if (bus.ls_req || bus.if_req) begin
        m_ls = bus.ls_req;
`ifdef MEM_ARB_RR_EN
        if (bus.ls_req && bus.if_req) m_ls = ptr_ls;
        ptr_ls = !m_ls;
`endif
        m_addr  = m_ls ? bus.ls_addr : bus.if_addr;
        m_we    = m_ls && bus.ls_we;
        m_wdata = bus.ls_wdata;
        k = 1;
      end
    end else if (k == ack_off(m_we)) begin
      k = 0;
    end else begin
      k++;
      if (k == ack_off(m_we)) begin
        if (m_we) begin
          mmem[m_addr[8:0]]    = m_wdata;
          mmem_wr[m_addr[8:0]] = 1'b1;
        end else begin
          exp_rdata = mmem_wr[m_addr[8:0]] ? mmem[m_addr[8:0]] : init_val(m_addr[8:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      chk("busy", bus.busy, k != 0);
      chk("mar_Rin", bus.mar_Rin, k == 1);
      if (k == 1) chk("mar_dIn", {23'h0, bus.mar_dIn[8:0]}, {23'h0, m_addr[8:0]});
      chk("ram_re", bus.ram_re, (k == 2) && !m_we);
      chk("ram_we", bus.ram_we, (k == 2) && m_we);
      if (k == 2 && m_we) chk("ram_wdata", bus.ram_wdata, m_wdata);
      chk("ls_ack", bus.ls_ack, (k == ack_off(m_we)) && m_ls);
      chk("if_ack", bus.if_ack, (k == ack_off(m_we)) && !m_ls);
      chk("rdata", bus.rdata, exp_rdata);
      chk("dut3_acks_exclusive", bus3.if_ack & bus3.ls_ack, 1'b0);
    end
  end

  task automatic txn(input bit ls, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat);
    @(negedge clk);
    if (ls) begin
      bus.ls_we = we; bus.ls_addr = addr; bus.ls_wdata = wdata; bus.ls_req = 1'b1;
    end else begin
      bus.if_addr = addr; bus.if_req = 1'b1;
    end
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ls ? bus.ls_ack : bus.if_ack) begin
        lat = n;
        break;
      end
    end
    bus.ls_req = 1'b0;
    bus.if_req = 1'b0;
  endtask

  int lat;
  int n_acks;
  logic [31:0] order [4];
  logic [31:0] exp_order [4];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus3.if_req = 0; bus3.if_addr = '0; bus3.ls_req = 0; bus3.ls_we = 0; bus3.ls_addr = '0; bus3.ls_wdata = '0;
`ifdef MEM_ARB_RR_EN
    exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
`else
    exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 1; exp_order[3] = 1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_acks", {bus.if_ack, bus.ls_ack}, 0);
    chk("rst_strobes", {bus.mar_Rin, bus.ram_re, bus.ram_we}, 0);
    #1 clr = 1'b1;

    txn(1'b0, 1'b0, 32'h0000_0123, 32'h0, lat);
    chk("fetch_lat", lat, 4);
    chk("fetch_rdata", bus.rdata, 32'hDEAD_BEEF);

    txn(1'b1, 1'b1, 32'hFFFF_F0AA, 32'h1234_5678, lat);
    chk("store_lat", lat, 3);
    chk("store_keeps_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("store_ram_0aa", mem[9'h0AA], 32'h1234_5678);

    txn(1'b0, 1'b0, 32'h0000_00AA, 32'h0, lat);
    chk("readback_lat", lat, 4);
    chk("readback_rdata", bus.rdata, 32'h1234_5678);

    // contention: both requesters held high across four grants
    @(negedge clk);
    bus.if_addr = 32'h10; bus.ls_addr = 32'h20; bus.ls_we = 1'b0;
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    n_acks = 0;
    for (int n = 0; n < 40 && n_acks < 4; n++) begin
      @(negedge clk);
      if (bus.ls_ack || bus.if_ack) begin
        order[n_acks] = {31'h0, bus.ls_ack};
        n_acks++;
      end
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    chk("arb_ack_count", n_acks, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb_grant_%0d", i), order[i], exp_order[i]);

    // mid-transaction change after grant
    @(negedge clk);
    bus.ls_we = 1'b0; bus.ls_addr = 32'h0000_0123; bus.ls_req = 1'b1;
    @(negedge clk);
    bus.ls_req = 1'b0; bus.ls_addr = 32'h55; bus.ls_we = 1'b1; bus.ls_wdata = 32'hFFFF_FFFF;
    n_acks = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.ls_ack) n_acks++;
    end
    bus.ls_we = 1'b0;
    chk("midchg_ack_count", n_acks, 1);
    chk("midchg_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("midchg_no_write", mem_wr[9'h055], 0);

    // reset while waiting on read data
    @(negedge clk);
    bus.if_addr = 32'h0000_00AA; bus.if_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    #1 clr = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_strobes", {bus.mar_Rin, bus.ram_re, bus.ram_we}, 0);
    chk("midrst_rdata", bus.rdata, 0);
    bus.if_req = 1'b0;
    n_acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.if_ack || bus.ls_ack || bus.ram_re || bus.ram_we) n_acks++;
    end
    chk("midrst_no_ack_or_strobe", n_acks, 0);
    #1 clr = 1'b1;

    // RD_LAT=3 instance
    @(negedge clk);
    bus3.if_addr = 32'h0000_0040; bus3.if_req = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus3.if_ack) begin
        lat = n;
        break;
      end
    end
    bus3.if_req = 1'b0;
    chk("rdlat3_lat", lat, 6);
    chk("rdlat3_rdata", bus3.rdata, 32'hCAFE_F00D);
    @(negedge clk);
    chk("rdlat3_idle", bus3.busy, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
